// File: rtl/button_led_ctrl_pkg.sv
// Purpose: shared types and helpers for the button/switch to LED controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: rgb_led_t, colour_t, colour_to_rgb(), colour_next().
package button_led_ctrl_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_led_t;

  typedef enum logic [1:0] {
    COL_OFF   = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } colour_t;

  function automatic rgb_led_t colour_to_rgb(input colour_t c);
    rgb_led_t rgb;
    rgb = '0;
    case (c)
      COL_RED:   rgb.r = 1'b1;
      COL_GREEN: rgb.g = 1'b1;
      COL_BLUE:  rgb.b = 1'b1;
      default:   rgb = '0;
    endcase
    return rgb;
  endfunction

  // OFF -> RED -> GREEN -> BLUE -> OFF; the 2-bit index wraps naturally.
  function automatic colour_t colour_next(input colour_t c);
    logic [1:0] idx;
    idx = c;
    idx = idx + 2'd1;
    return colour_t'(idx);
  endfunction

endpackage

// File: rtl/button_led_ctrl_debounce.sv
// Purpose: 2-flop synchroniser followed by a stable-count debouncer for one raw input.
// Latency: 2 cycles to synchronised level, then PERIOD stable cycles to a new debounced level.
// Backpressure: none; free-running level filter.
// Ports: clk_i, rst_i (async active-low), in (raw async level), out (debounced level).
module button_led_ctrl_debounce #(
  parameter int PERIOD = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      // Agreement (or a glitch that reverted) restarts the stability count.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This cycle completes PERIOD consecutive differing cycles.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = level_q;

endmodule

// File: rtl/button_led_ctrl.sv
// Purpose: per-channel debounced buttons/switches driving a green LED (direct/toggle) and an RGB colour LED.
// Latency: raw button edge to green LED is DEBOUNCE_PERIOD+3 cycles; debounced change to LEDs is 1 cycle.
// Backpressure: none; pin-to-pin path with no handshake.
// Ports: clk_i, rst_i (async active-low), buttons/switches [N_CHANNELS] raw, green_leds/rgb_leds registered.
module button_led_ctrl
  import button_led_ctrl_pkg::*;
#(
  parameter int N_CHANNELS      = 4,
  parameter int DEBOUNCE_PERIOD = 5_000_000,
  parameter int BLINK_PERIOD    = 25_000_000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CHANNELS-1:0]     buttons,
  input  logic [N_CHANNELS-1:0]     switches,
  output logic [N_CHANNELS-1:0]     green_leds,
  output rgb_led_t [N_CHANNELS-1:0] rgb_leds
);

  localparam int BCW = $clog2(BLINK_PERIOD);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIOD - 1);

  // Shared blink generator: phase flips each time the counter wraps.
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BCW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
    logic     btn_db, sw_db;
    logic     btn_prev_q, btn_prev_d;
    logic     sw_prev_q, sw_prev_d;
    logic     toggle_q, toggle_d;
    logic     green_q, green_d;
    colour_t  colour_q, colour_d;
    rgb_led_t rgb_q, rgb_d;
    logic     press, mode_chg;

    button_led_ctrl_debounce #(.PERIOD(DEBOUNCE_PERIOD)) u_btn_db (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .in    (buttons[ch]),
      .out   (btn_db)
    );

    button_led_ctrl_debounce #(.PERIOD(DEBOUNCE_PERIOD)) u_sw_db (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .in    (switches[ch]),
      .out   (sw_db)
    );

    always_comb begin
      btn_prev_d = btn_db;
      sw_prev_d  = sw_db;
      press      = btn_db & ~btn_prev_q;
      mode_chg   = sw_db ^ sw_prev_q;

      // A mode change wins over a coincident press for the toggle state.
      toggle_d = toggle_q;
      if (mode_chg) begin
        toggle_d = 1'b0;
      end else if (press) begin
        toggle_d = ~toggle_q;
      end

      // Colour advances on every press regardless of mode or mode change.
      colour_d = press ? colour_next(colour_q) : colour_q;

      // Outputs use next-state values so LEDs lag the debounced level by one cycle.
      green_d = sw_db ? toggle_d : btn_db;
      rgb_d   = colour_to_rgb(colour_d);
      if (sw_db && !blink_phase_d) begin
        rgb_d = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        btn_prev_q <= 1'b0;
        sw_prev_q  <= 1'b0;
        toggle_q   <= 1'b0;
        colour_q   <= COL_OFF;
        green_q    <= 1'b0;
        rgb_q      <= '0;
      end else begin
        btn_prev_q <= btn_prev_d;
        sw_prev_q  <= sw_prev_d;
        toggle_q   <= toggle_d;
        colour_q   <= colour_d;
        green_q    <= green_d;
        rgb_q      <= rgb_d;
      end
    end

    assign green_leds[ch] = green_q;
    assign rgb_leds[ch]   = rgb_q;
  end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Purpose: self-checking bench for button_led_ctrl with short debounce and blink periods.
// Latency: outputs sampled on the falling edge; settle holds exceed the 7-cycle pin-to-LED delay.
// Backpressure: n/a.
module tb_button_led_ctrl;
  import button_led_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int BP = 8;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] BLU = 3'b001;

  logic             clk_i;
  logic             rst_i;
  logic [N-1:0]     buttons;
  logic [N-1:0]     switches;
  logic [N-1:0]     green_leds;
  rgb_led_t [N-1:0] rgb_leds;

  int n_pass;
  int n_total;
  int cyc;

  button_led_ctrl #(
    .N_CHANNELS      (N),
    .DEBOUNCE_PERIOD (DB),
    .BLINK_PERIOD    (BP)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .buttons    (buttons),
    .switches   (switches),
    .green_leds (green_leds),
    .rgb_leds   (rgb_leds)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Edges since reset release; blink phase is (cyc / BP) % 2 at the sample point.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [N-1:0] btn;
    logic [N-1:0] exp_green;
    logic [11:0]  exp_rgb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    buttons  = '0;
    switches = '0;
    rst_i    = 1'b0;
    step(2);
    rst_i    = 1'b1;
  endtask

  task automatic press(input int ch);
    buttons[ch] = 1'b1;
    step(10);
    buttons[ch] = 1'b0;
    step(10);
  endtask

  function automatic logic [2:0] rgb_of(input int ch);
    logic [11:0] all;
    all = rgb_leds;
    return all[ch*3 +: 3];
  endfunction

  function automatic logic [2:0] blinked(input logic [2:0] c);
    return (((cyc / BP) % 2) == 1) ? c : OFF;
  endfunction

  initial begin
    int glitch;
    int first_rise;
    int mism;
    int on_cnt;
    logic [2:0] col_seq [5];

    n_pass   = 0;
    n_total  = 0;
    rst_i    = 1'b0;
    buttons  = '0;
    switches = '0;

    // DIRECT mode vectors; colours accumulate over rising edges per channel.
    vecs[0] = '{btn: 4'b0001, exp_green: 4'b0001, exp_rgb: {OFF, OFF, OFF, RED}};
    vecs[1] = '{btn: 4'b0000, exp_green: 4'b0000, exp_rgb: {OFF, OFF, OFF, RED}};
    vecs[2] = '{btn: 4'b1010, exp_green: 4'b1010, exp_rgb: {RED, OFF, RED, RED}};
    vecs[3] = '{btn: 4'b1011, exp_green: 4'b1011, exp_rgb: {RED, OFF, RED, GRN}};
    vecs[4] = '{btn: 4'b0000, exp_green: 4'b0000, exp_rgb: {RED, OFF, RED, GRN}};
    vecs[5] = '{btn: 4'b1111, exp_green: 4'b1111, exp_rgb: {GRN, RED, GRN, BLU}};
    vecs[6] = '{btn: 4'b0000, exp_green: 4'b0000, exp_rgb: {GRN, RED, GRN, BLU}};
    col_seq = '{RED, GRN, BLU, OFF, RED};

    // Reset state while asserted.
    #12;
    check("reset_green", 32'(green_leds), 32'h0);
    check("reset_rgb", 32'(rgb_leds), 32'h0);
    step(1);
    rst_i = 1'b1;

    // Table-driven DIRECT mode.
    for (int i = 0; i < 7; i++) begin
      buttons = vecs[i].btn;
      step(10);
      check($sformatf("vec%0d_green", i), 32'(green_leds), 32'(vecs[i].exp_green));
      check($sformatf("vec%0d_rgb", i), 32'(rgb_leds), 32'(vecs[i].exp_rgb));
    end

    // Bounce rejection on channel 0.
    do_reset();
    step(2);
    glitch = 0;
    first_rise = 0;
    buttons[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin step(1); if (green_leds[0]) glitch++; end
    buttons[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin step(1); if (green_leds[0]) glitch++; end
    buttons[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (green_leds[0] && first_rise == 0) first_rise = k;
    end
    check("bounce_no_glitch", 32'(glitch), 32'd0);
    check("bounce_latency", 32'(first_rise), 32'd7);
    check("bounce_one_press", 32'(rgb_of(0)), 32'(RED));

    // Colour sequence on channel 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(1);
      check($sformatf("colour_seq%0d", i), 32'(rgb_of(1)), 32'(col_seq[i]));
    end

    // Toggle and blink on channel 2.
    do_reset();
    switches[2] = 1'b1;
    step(10);
    buttons[2] = 1'b1;
    step(10);
    check("toggle_first", 32'(green_leds[2]), 32'd1);
    buttons[2] = 1'b0;
    step(10);
    buttons[2] = 1'b1;
    step(10);
    check("toggle_second", 32'(green_leds[2]), 32'd0);
    mism = 0;
    on_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (rgb_of(2) !== blinked(GRN)) mism++;
      if (rgb_of(2) === GRN) on_cnt++;
    end
    check("blink_pattern", 32'(mism), 32'd0);
    check("blink_on_count", 32'(on_cnt), 32'd16);
    buttons[2] = 1'b0;

    // Mode change clears toggle on channel 3.
    do_reset();
    switches[3] = 1'b1;
    step(10);
    buttons[3] = 1'b1;
    step(10);
    check("mc_toggle_set", 32'(green_leds[3]), 32'd1);
    buttons[3] = 1'b0;
    step(10);
    check("mc_toggle_hold", 32'(green_leds[3]), 32'd1);
    switches[3] = 1'b0;
    buttons[3]  = 1'b1;
    step(10);
    check("mc_direct_green", 32'(green_leds[3]), 32'd1);
    check("mc_colour_adv", 32'(rgb_of(3)), 32'(GRN));
    buttons[3] = 1'b0;
    step(10);
    check("mc_direct_follow", 32'(green_leds[3]), 32'd0);
    switches[3] = 1'b1;
    buttons[3]  = 1'b1;
    step(10);
    check("mc_override_press", 32'(green_leds[3]), 32'd0);
    check("mc_colour_blue", 32'(rgb_of(3)), 32'(blinked(BLU)));

    // Channel independence.
    do_reset();
    buttons = 4'b1001;
    step(10);
    check("indep_green", 32'(green_leds), 32'h9);
    check("indep_rgb", 32'(rgb_leds), 32'({RED, OFF, OFF, RED}));

    // Asynchronous reset mid-operation: colour BLUE, toggle 1 on channel 0.
    do_reset();
    switches[0] = 1'b1;
    step(10);
    press(0);
    press(0);
    press(0);
    check("rst_mid_pre_green", 32'(green_leds[0]), 32'd1);
    #3;
    rst_i    = 1'b0;
    buttons  = '0;
    switches = '0;
    #1;
    check("rst_mid_green", 32'(green_leds), 32'h0);
    check("rst_mid_rgb", 32'(rgb_leds), 32'h0);
    step(2);
    rst_i = 1'b1;
    step(10);
    check("rst_post_green", 32'(green_leds), 32'h0);
    check("rst_post_rgb", 32'(rgb_leds), 32'h0);
    buttons[0] = 1'b1;
    step(10);
    check("rst_post_colour", 32'(rgb_leds), 32'({OFF, OFF, OFF, RED}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_led_ctrl.md
# button_led_ctrl

Parametrised, self-contained successor to the fixed four-channel buttons-to-LEDs path. It handles N_CHANNELS button/switch pairs, with no bus in between. Per channel it synchronises and debounces both inputs, then detects button presses. It drives one green LED (direct or toggle mode, chosen by the switch) and one RGB LED, which steps through a colour sequence on each press and blinks in toggle mode. It sits directly between board pins and LED pins.

## Interface
- N_CHANNELS, 4, number of button/switch/LED channels (≥1)
- DEBOUNCE_PERIOD, 5_000_000, consecutive stable cycles required before a debounced level changes (≥1)
- BLINK_PERIOD, 25_000_000, cycles per blink half-period (≥2)
- clk_i  input  1  single system clock
- rst_i  input  1  reset, asynchronous, active-low
- buttons  input  N_CHANNELS  raw push buttons, asynchronous to clk_i, active-high
- switches  input  N_CHANNELS  raw slide switches, asynchronous, active-high
- green_leds  output  N_CHANNELS  green LEDs, registered
- rgb_leds  output  rgb_led_t [N_CHANNELS-1:0]  RGB LEDs ({r,g,b}), registered

## Operation
- Reset (rst_i low, any time, asynchronous):
  - synchronisers, debounced levels, debounce counters, toggle states, colour indices, blink counter and blink phase all clear to 0 / COL_OFF;
  - green_leds = 0 and rgb_leds = all-off while reset is asserted and on release.
- Synchronise: every raw input passes through a 2-flop synchroniser.
- Debounce, per input, independent:
  - counter clears whenever the synchronised level equals the debounced level;
  - otherwise the counter increments;
  - on the cycle it would reach DEBOUNCE_PERIOD, the debounced level takes the synchronised level and the counter clears;
  - counter width $clog2(DEBOUNCE_PERIOD+1), never wraps.
- Press: one-cycle pulse on the 0→1 transition of the debounced button.
- Mode, from the debounced switch: 0 = DIRECT, 1 = TOGGLE.
- Green LED:
  - DIRECT: green = debounced button;
  - TOGGLE: each press inverts the toggle state; green = toggle state.
- Mode change: any debounced-switch transition clears the toggle state to 0 that cycle. This overrides a coincident press.
- Colour:
  - each press advances a 2-bit index OFF→RED→GREEN→BLUE→OFF (wraps 3→0);
  - presses advance the colour in both modes;
  - a coincident mode change does not suppress the advance.
- RGB LED:
  - decode of the colour index (RED={1,0,0}, GREEN={0,1,0}, BLUE={0,0,1}, OFF={0,0,0});
  - in TOGGLE mode the decode is ANDed with blink phase.
- Blink generator, shared by all channels:
  - counter 0..BLINK_PERIOD-1, wraps to 0;
  - blink phase inverts on each wrap.

## Timing
- Raw input change to synchronised level: 2 cycles.
- Synchronised change held stable to debounced change: DEBOUNCE_PERIOD cycles.
- Debounced change to LED output: 1 cycle (registered outputs).
- Total, raw button edge to green_leds (DIRECT): DEBOUNCE_PERIOD+3 cycles.
- Bounce shorter than DEBOUNCE_PERIOD: a glitch that reverts before the count completes resets the counter; no output change.
- Blink phase period: 2·BLINK_PERIOD cycles.
  - The first inversion occurs BLINK_PERIOD cycles after reset release.
  - Phase is 0 (RGB dark in TOGGLE) for the first half-period.
- Channels are fully independent. Simultaneous presses on several channels are each handled in the same cycle.

## Structure
- Shared package types:
  - rgb_led_t (existing);
  - add colour_t enum {COL_OFF, COL_RED, COL_GREEN, COL_BLUE} as 2-bit logic;
  - add function colour_to_rgb(colour_t) returning rgb_led_t.
- Sub-module debounce:
  - parameter PERIOD; ports clk_i, rst_i, in, out;
  - includes the 2-flop synchroniser;
  - instantiated 2·N_CHANNELS times through a generate loop.
- Top-level generate loop per channel: edge detect, toggle, colour registers.
- One blink counter in the top level.

## Test plan
Bench: N_CHANNELS=4, DEBOUNCE_PERIOD=4, BLINK_PERIOD=8.
- Reset mid-operation: colour=BLUE and toggle=1, pull rst_i low asynchronously -> green_leds=0 and rgb_leds all-off immediately; state stays cleared after release.
- Bounce rejection: button[0] high for 3 cycles, low, then high for 10 cycles, switch=0 -> one green_leds[0] rise, exactly 7 cycles after the final rising edge; no earlier change.
- Colour sequence: 5 clean presses on button[1], switch=0 -> rgb_leds[1] steps RED, GREEN, BLUE, OFF, RED.
- Toggle and blink: switch[2]=1, two presses on button[2] -> green_leds[2] goes 1 then 0. rgb_leds[2]=GREEN appears only while blink phase=1 (alternating 8-cycle windows).
- Mode change clears state: toggle=1 on ch3, then switch[3] 1→0 debounced in the same cycle as a press -> toggle cleared, green follows the debounced button, colour still advances by one.
- Channel independence: presses on channels 0 and 3 in the same cycle -> both colours advance; channels 1 and 2 unchanged.
